// File: rtl/mp_pf_icache_maint_pkg.sv
// Shared types and widths for the icache maintenance sequencer.
package mp_pf_icache_maint_pkg;

    localparam int unsigned MAINT_ADDR_W = 32;
    localparam int unsigned MAINT_SIZE_W = 8;
    localparam int unsigned MAINT_OP_W   = 3;

    typedef enum logic [MAINT_OP_W-1:0] {
        OP_FLUSH      = 3'd0,
        OP_SEL_FLUSH  = 3'd1,
        OP_PREFETCH   = 3'd2,
        OP_BYPASS_ON  = 3'd3,
        OP_BYPASS_OFF = 3'd4,
        OP_STAT_CLEAR = 3'd5,
        OP_STAT_EN    = 3'd6,
        OP_STAT_DIS   = 3'd7
    } maint_op_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESP      = 2'd3
    } maint_state_e;

    typedef struct packed {
        maint_op_e               op;
        logic [MAINT_ADDR_W-1:0] addr;
        logic [MAINT_SIZE_W-1:0] size;
    } maint_cmd_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mp_pf_icache_maint_sched_if.sv
// Requester command bus plus cache-controller maintenance handshakes.
interface mp_pf_icache_maint_sched_if #(
    parameter int unsigned NB_REQ   = 4,
    parameter int unsigned NB_CORES = 4
);
    import mp_pf_icache_maint_pkg::*;

    logic [NB_REQ-1:0]                        req_valid_i;
    logic [NB_REQ-1:0]                        req_ready_o;
    logic [NB_REQ-1:0][MAINT_OP_W-1:0]        req_op_i;
    logic [NB_REQ-1:0][MAINT_ADDR_W-1:0]      req_addr_i;
    logic [NB_REQ-1:0][MAINT_SIZE_W-1:0]      req_size_i;
    logic [NB_REQ-1:0]                        rsp_valid_o;
    logic                                     rsp_err_o;
    logic                                     busy_o;
    logic                                     bypass_req_o;
    logic [NB_CORES:0]                        bypass_ack_i;
    logic                                     flush_req_o;
    logic                                     flush_ack_i;
    logic                                     sel_flush_req_o;
    logic [MAINT_ADDR_W-1:0]                  sel_flush_addr_o;
    logic                                     sel_flush_ack_i;
    logic                                     pf_req_o;
    logic [MAINT_ADDR_W-1:0]                  pf_addr_o;
    logic [MAINT_SIZE_W-1:0]                  pf_size_o;
    logic                                     pf_ack_i;
    logic                                     pf_done_i;
    logic                                     ctrl_clear_regs_o;
    logic                                     ctrl_enable_regs_o;

    modport slave (
        input  req_valid_i, req_op_i, req_addr_i, req_size_i,
               bypass_ack_i, flush_ack_i, sel_flush_ack_i, pf_ack_i, pf_done_i,
        output req_ready_o, rsp_valid_o, rsp_err_o, busy_o, bypass_req_o,
               flush_req_o, sel_flush_req_o, sel_flush_addr_o,
               pf_req_o, pf_addr_o, pf_size_o, ctrl_clear_regs_o, ctrl_enable_regs_o
    );

    modport master (
        output req_valid_i, req_op_i, req_addr_i, req_size_i,
               bypass_ack_i, flush_ack_i, sel_flush_ack_i, pf_ack_i, pf_done_i,
        input  req_ready_o, rsp_valid_o, rsp_err_o, busy_o, bypass_req_o,
               flush_req_o, sel_flush_req_o, sel_flush_addr_o,
               pf_req_o, pf_addr_o, pf_size_o, ctrl_clear_regs_o, ctrl_enable_regs_o
    );

endinterface

// File: rtl/mp_pf_icache_maint_rr_arb.sv
// Round-robin arbiter; search starts one past the last grant, pointer moves only on update.
module mp_pf_icache_maint_rr_arb
    import mp_pf_icache_maint_pkg::*;
#(
    parameter  int unsigned NB_REQ = 4,
    localparam int unsigned IDX_W  = idx_width(NB_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NB_REQ-1:0] valid,
    input  logic              update,
    output logic [NB_REQ-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic             found;
    int unsigned      cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int unsigned i = 1; i <= NB_REQ; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NB_REQ) cand = cand - NB_REQ;
            if (!found && valid[IDX_W'(cand)]) begin
                found                 = 1'b1;
                grant[IDX_W'(cand)]   = 1'b1;
                grant_idx             = IDX_W'(cand);
            end
        end
    end

    // Reset value makes requester 0 the first candidate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= IDX_W'(NB_REQ - 1);
        end else if (update && found) begin
            ptr_q <= grant_idx;
        end
    end

endmodule

// File: rtl/mp_pf_icache_maint_sched.sv
// Maintenance command sequencer: arbitrates requesters and runs one cache handshake at a time.
module mp_pf_icache_maint_sched
    import mp_pf_icache_maint_pkg::*;
#(
    parameter int unsigned NB_REQ   = 4,
    parameter int unsigned NB_CORES = 4,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    mp_pf_icache_maint_sched_if.slave   bus
);

    localparam int unsigned IDX_W = idx_width(NB_REQ);
    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit          TO_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    maint_state_e     state_q, state_d;
    maint_cmd_t       cmd_q, cmd_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
    logic             bypass_q, bypass_d;
    logic             en_q, en_d;

    logic [NB_REQ-1:0] grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              accept_c;
    logic              to_hit_c;
    logic              issue_done_c;
    logic              pf_wait_c;
    maint_op_e         acc_op_c;
    logic [NB_CORES:0] bypass_ack;

    assign bypass_ack = bus.bypass_ack_i;
    assign accept_c   = (state_q == ST_IDLE) && (|bus.req_valid_i) && !rst_i;
    assign acc_op_c   = maint_op_e'(bus.req_op_i[grant_idx]);
    assign to_hit_c   = TO_EN && (cnt_q == CNT_LAST);

    mp_pf_icache_maint_rr_arb #(.NB_REQ(NB_REQ)) u_arb (
        .clk       (clk_i),
        .rst       (rst_i),
        .valid     (bus.req_valid_i),
        .update    (accept_c),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            to_q     <= 1'b0;
            bypass_q <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            bypass_q <= bypass_d;
            en_q     <= en_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q + CNT_W'(1);
        to_d         = to_q;
        bypass_d     = bypass_q;
        en_d         = en_q;
        issue_done_c = 1'b0;
        pf_wait_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    owner_d    = grant_idx;
                    cmd_d.op   = acc_op_c;
                    cmd_d.addr = bus.req_addr_i[grant_idx];
                    cmd_d.size = bus.req_size_i[grant_idx];
                    cnt_d      = '0;
                    to_d       = 1'b0;
                    state_d    = ST_ISSUE;
                    // Bypass and stat-enable take effect at acceptance, not at completion.
                    case (acc_op_c)
                        OP_BYPASS_ON:  bypass_d = 1'b1;
                        OP_BYPASS_OFF: bypass_d = 1'b0;
                        OP_STAT_EN:    en_d     = 1'b1;
                        OP_STAT_DIS:   en_d     = 1'b0;
                        default:       ;
                    endcase
                end
            end
            ST_ISSUE: begin
                case (cmd_q.op)
                    OP_FLUSH:      issue_done_c = bus.flush_ack_i;
                    OP_SEL_FLUSH:  issue_done_c = bus.sel_flush_ack_i;
                    OP_PREFETCH: begin
                        issue_done_c = bus.pf_ack_i && bus.pf_done_i;
                        pf_wait_c    = bus.pf_ack_i && !bus.pf_done_i;
                    end
                    OP_BYPASS_ON:  issue_done_c = &bypass_ack;
                    OP_BYPASS_OFF: issue_done_c = ~|bypass_ack;
                    default:       issue_done_c = 1'b1;
                endcase
                if (issue_done_c) begin
                    state_d = ST_RESP;
                end else if (pf_wait_c) begin
                    state_d = ST_WAIT_DONE;
                end else if (to_hit_c) begin
                    state_d = ST_RESP;
                    to_d    = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.pf_done_i) begin
                    state_d = ST_RESP;
                end else if (to_hit_c) begin
                    state_d = ST_RESP;
                    to_d    = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Cache-side requests decode only flopped state/op, never an ack.
    assign bus.req_ready_o        = accept_c ? grant : '0;
    assign bus.busy_o             = (state_q != ST_IDLE);
    assign bus.rsp_valid_o        = (state_q == ST_RESP) ? (NB_REQ'(1) << owner_q) : '0;
    assign bus.rsp_err_o          = (state_q == ST_RESP) && to_q;
    assign bus.flush_req_o        = (state_q == ST_ISSUE) && (cmd_q.op == OP_FLUSH);
    assign bus.sel_flush_req_o    = (state_q == ST_ISSUE) && (cmd_q.op == OP_SEL_FLUSH);
    assign bus.pf_req_o           = (state_q == ST_ISSUE) && (cmd_q.op == OP_PREFETCH);
    assign bus.ctrl_clear_regs_o  = (state_q == ST_ISSUE) && (cmd_q.op == OP_STAT_CLEAR);
    assign bus.sel_flush_addr_o   = cmd_q.addr;
    assign bus.pf_addr_o          = cmd_q.addr;
    assign bus.pf_size_o          = cmd_q.size;
    assign bus.bypass_req_o       = bypass_q;
    assign bus.ctrl_enable_regs_o = en_q;

endmodule
